pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register carrying an arbitrary payload between adjacent CPU pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It adds a valid/ready handshake, a 2-entry skid buffer for full throughput with a registered ready, and synchronous flush and freeze controls. Each stage boundary instantiates one copy, sized by `DATA_W`.

## Interface
- `DATA_W`, default 64: payload width in bits, for example PC plus instruction.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `flush` input, 1 bit: synchronous squash of all held entries.
- `freeze` input, 1 bit: synchronous hold of the output side.
- `in_valid` input, 1 bit: upstream presents `in_data`.
- `in_ready` output, 1 bit: stage can accept a beat.
- `in_data` input, `DATA_W` bits: upstream payload.
- `out_valid` output, 1 bit: `out_data` holds a live beat.
- `out_ready` input, 1 bit: downstream accepts the beat.
- `out_data` output, `DATA_W` bits: head payload.
- `occupancy` output, 2 bits: held entries, 0 to 2.

## Operation
- Push: `in_valid && in_ready && !flush`.
- Pop: `out_valid && out_ready && !freeze && !flush`.
- Storage: a main register drives `out_data`; a skid register is used only in FULL.
- States:
  - EMPTY (occupancy 0)
  - HALF (1)
  - FULL (2)
- Transitions:
  - EMPTY, push -> HALF; main <= in_data.
  - HALF, push and no pop -> FULL; skid <= in_data.
  - HALF, push and pop -> HALF; main <= in_data.
  - HALF, pop only -> EMPTY.
  - FULL, pop -> HALF; main <= skid. No push is possible in FULL.
- Outputs:
  - `out_valid` = (state != EMPTY).
  - `in_ready` is registered and equals (next_state != FULL).
- Priority: reset > flush > freeze > normal.
- Flush:
  - Next state is EMPTY.
  - Main and skid registers are cleared to 0.
  - A same-cycle `in_valid` beat is dropped.
  - `in_ready` is 1 on the following cycle.
- Freeze:
  - Blocks pop only; `out_valid` and `out_data` are held.
  - Pushes still land while `in_ready` is 1, so a frozen stage fills to FULL and then back-pressures.
- On pop to EMPTY, `out_data` keeps its last value; it is zeroed only by reset or flush.
- Payload is never modified or reordered; strict FIFO order.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `out_valid` = 0
  - `out_data` = 0
  - `occupancy` = 0
  - `in_ready` = 1
  - internal registers = 0
- Reset release: the first push can occur at the first rising edge with `rst_n` high.
- Latency: a beat pushed at edge N is visible on `out_data` with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle sustained with `out_ready` held high.
- Back-pressure: `in_ready` drops one cycle after `out_ready` falls with one entry held; the in-flight beat lands in skid and none are lost.
- Combinational paths: no path from `out_ready` to `in_ready` in the skid build.
- Reset mid-operation: all held beats are discarded with no partial state.
- Flush and freeze together: flush wins.

## Configuration
- Macro: `PIPE_STAGE_REG_SKID_EN`.
- Defined (default build): 2-entry skid buffer exactly as above; `in_ready` is registered; `occupancy` ranges 0 to 2.
- Undefined:
  - Single-entry register; states EMPTY and HALF only.
  - `in_ready` = !out_valid || (out_ready && !freeze), a combinational path.
  - `occupancy` is 0 or 1; flush, freeze and reset semantics are unchanged.
  - Throughput stays one beat per cycle.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum typedef `pipe_state_t` (EMPTY, HALF, FULL)
  - the `OCC_W` = 2 constant
  - the `PIPE_FLUSH_VAL` = 0 constant used for clearing
- Single module with no sub-module; main and skid registers are inline.

## Test plan
- Reset with `in_valid` = 1 and `in_data` = 0xDEADBEEF_00000004 -> outputs are 0, `in_ready` = 1; after release the beat appears on `out_data` one cycle later.
- Stream 0x1, 0x2, 0x3, 0x4 on consecutive cycles with `out_ready` = 1 -> outputs appear in order on consecutive cycles and `occupancy` stays 1.
- `out_ready` = 0 while streaming 0xA, 0xB, 0xC -> `occupancy` reaches 2 and `in_ready` = 0; 0xC is held upstream; after release the outputs are 0xA, 0xB, 0xC with no loss.
- `freeze` = 1 for 3 cycles with `out_ready` = 1 -> `out_data` is held; the stage fills to 2 and drains in order when freeze drops.
- `flush` at FULL together with `in_valid` 0x55 -> next cycle `out_valid` = 0, `out_data` = 0, `occupancy` = 0, `in_ready` = 1; 0x55 never appears.
- Build without `PIPE_STAGE_REG_SKID_EN`, hold `out_ready` = 0 -> `in_ready` = 0 in the same cycle and `occupancy` never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register.
package pipe_pkg;

  localparam int OCC_W = 2;

  // Clearing value for payload registers on reset and flush
  localparam logic PIPE_FLUSH_VAL = 1'b0;

  // The encoding doubles as the occupancy count
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, flush and freeze.
// Build option PIPE_STAGE_REG_SKID_EN: when defined, a 2-entry skid buffer
// with a registered in_ready; when undefined, a single-entry register whose
// in_ready depends combinationally on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic              push, pop;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
`endif

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_REG_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || (out_ready && !freeze);
`endif

  // Flush suppresses both sides; freeze only blocks the output side
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !freeze && !flush;

  // Next-state and payload steering
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      main_d  = {DATA_W{PIPE_FLUSH_VAL}};
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_d  = {DATA_W{PIPE_FLUSH_VAL}};
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = HALF;
            main_d  = in_data;
          end
        end
        HALF: begin
          if (push && pop) begin
            main_d = in_data;
`ifdef PIPE_STAGE_REG_SKID_EN
          end else if (push) begin
            state_d = FULL;
            skid_d  = in_data;
`endif
          end else if (pop) begin
            // out_data keeps its last value when draining to empty
            state_d = EMPTY;
          end
        end
`ifdef PIPE_STAGE_REG_SKID_EN
        FULL: begin
          // in_ready is low here, so only a pop can happen
          if (pop) begin
            state_d = HALF;
            main_d  = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
`ifdef PIPE_STAGE_REG_SKID_EN
    in_ready_d = (state_d != FULL);
`endif
  end

  // State, payload and ready registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, so out_data reads 0 straight out of reset.
      state_q    <= EMPTY;
      main_q     <= {DATA_W{PIPE_FLUSH_VAL}};
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q     <= {DATA_W{PIPE_FLUSH_VAL}};
      in_ready_q <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      state_q    <= state_d;
      main_q     <= main_d;
`ifdef PIPE_STAGE_REG_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; expectations follow the
// build option PIPE_STAGE_REG_SKID_EN the same way the design does.
module tb_pipe_stage_reg;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              freeze;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                           input logic [1:0] occ);
    check({tag, "_valid"}, out_valid, v);
    check({tag, "_data"}, out_data, d);
    check({tag, "_occ"}, occupancy, occ);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    freeze    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEADBEEF_00000004;
    out_ready = 1'b0;

    // Reset holds everything clear even with a beat offered
    tick();
    tick();
    check_out("rst", 1'b0, 64'h0, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // First edge after release takes the beat
    rst_n = 1'b1;
    tick();
    check_out("first", 1'b1, 64'hDEADBEEF_00000004, 2'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("drain_keep", 1'b0, 64'hDEADBEEF_00000004, 2'd0);

    // Full-throughput stream
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, 64'(i), 2'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_occ", occupancy, 2'd0);

    // Back-pressure with 0xA, 0xB, 0xC
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hA;
    tick();
    check_out("bp_a", 1'b1, 64'hA, 2'd1);
    in_data = 64'hB;
`ifdef PIPE_STAGE_REG_SKID_EN
    check("bp_rdy_half", in_ready, 1'b1);
    tick();
    check_out("bp_full", 1'b1, 64'hA, 2'd2);
    check("bp_rdy_full", in_ready, 1'b0);
    in_data = 64'hC;
    tick();
    check_out("bp_hold", 1'b1, 64'hA, 2'd2);
    out_ready = 1'b1;
    tick();
    check_out("bp_pop_b", 1'b1, 64'hB, 2'd1);
    check("bp_rdy_back", in_ready, 1'b1);
`else
    #1;
    check("bp_rdy_comb", in_ready, 1'b0);
    tick();
    check_out("bp_hold", 1'b1, 64'hA, 2'd1);
    out_ready = 1'b1;
    #1;
    check("bp_rdy_comb_up", in_ready, 1'b1);
    tick();
    check_out("bp_pop_b", 1'b1, 64'hB, 2'd1);
    in_data = 64'hC;
`endif
    tick();
    check_out("bp_pop_c", 1'b1, 64'hC, 2'd1);
    in_valid = 1'b0;
    tick();
    check("bp_end_occ", occupancy, 2'd0);

    // Freeze for three cycles with out_ready high
    freeze   = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h11;
    tick();
    check_out("frz_1", 1'b1, 64'h11, 2'd1);
`ifdef PIPE_STAGE_REG_SKID_EN
    in_data = 64'h12;
    tick();
    check_out("frz_2", 1'b1, 64'h11, 2'd2);
    check("frz_rdy", in_ready, 1'b0);
    in_data = 64'h13;
    tick();
    check_out("frz_3", 1'b1, 64'h11, 2'd2);
    freeze = 1'b0;
    tick();
    check_out("frz_pop12", 1'b1, 64'h12, 2'd1);
`else
    in_data = 64'h12;
    tick();
    check_out("frz_2", 1'b1, 64'h11, 2'd1);
    check("frz_rdy", in_ready, 1'b0);
    tick();
    check_out("frz_3", 1'b1, 64'h11, 2'd1);
    freeze = 1'b0;
    tick();
    check_out("frz_pop12", 1'b1, 64'h12, 2'd1);
    in_data = 64'h13;
`endif
    tick();
    check_out("frz_pop13", 1'b1, 64'h13, 2'd1);
    in_valid = 1'b0;
    tick();
    check("frz_end_occ", occupancy, 2'd0);

    // Fill, then flush together with freeze and an offered 0x55
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h21;
    tick();
`ifdef PIPE_STAGE_REG_SKID_EN
    in_data = 64'h22;
    tick();
    check("fl_pre_occ", occupancy, 2'd2);
`else
    check("fl_pre_occ", occupancy, 2'd1);
`endif
    flush   = 1'b1;
    freeze  = 1'b1;
    in_data = 64'h55;
    tick();
    check_out("flush", 1'b0, 64'h0, 2'd0);
    check("flush_rdy", in_ready, 1'b1);
    flush     = 1'b0;
    freeze    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check_out("flush_after", 1'b0, 64'h0, 2'd0);

    // Asynchronous reset mid-operation discards the held beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    tick();
    check_out("pre_rst", 1'b1, 64'h77, 2'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 64'h0, 2'd0);
    check("async_rst_rdy", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_occ", occupancy, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_stage_reg
